imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV32I/RV64I decode stage.
- Accepts one instruction word per cycle over a valid/ready handshake.
- Classifies the instruction format, builds the sign-/zero-extended immediate at XLEN width, flags illegal opcodes, and buffers results in a 2-entry output queue so downstream stalls do not drop instructions.
- Sits between fetch and register-read; replaces the single-edge, 32-bit-only immediate extender.

Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 or 64.
- TAG_W, 5, width of the opaque sideband tag (e.g. ROB/PC index) carried with each instruction.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head result valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the head entry.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted.

Behaviour:
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Decode is combinational on in_instr; the result is written into a 2-entry FIFO on accept.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready = (count < 2), driven from registered state only; it has no combinational path from out_ready.
- count update: +1 on accept only; -1 on pop only; unchanged on simultaneous accept+pop (including count==1).
- When count==2 there is no accept. A pop that cycle makes in_ready=1 the next cycle.
- out_valid = (count != 0).
- out_imm, out_fmt, out_illegal and out_tag show the head entry and are forced to 0 when out_valid=0.
- Head outputs must stay stable while out_valid && !out_ready.
- Opcode decode (in_instr[6:0]); "sx" = sign-extend to XLEN:
  - 0010011 OP-IMM: funct3 001/101 gives SHAMT, imm = zero-extended in[24:20] (XLEN=32) or in[25:20] (XLEN=64). Other funct3 gives I.
  - 0000011 LOAD, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM: I, imm = sx(in[31:20]).
  - 0100011 STORE: S, imm = sx({in[31:25],in[11:7]}).
  - 1100011 BRANCH: B, imm = sx({in[31],in[7],in[30:25],in[11:8],1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U, imm = sx({in[31:12],12'b0}).
  - 1101111 JAL: J, imm = sx({in[31],in[19:12],in[20],in[30:21],1'b0}).
  - 0110011 OP: NONE, imm=0, legal.
  - Any other opcode: NONE, imm=0, out_illegal=1. The value is never X.
- illegal_cnt increments by 1 on each accept of an illegal instruction and saturates at all-ones. Pops do not affect it.
- Reset (rst=1 at a clock edge): count=0, out_valid=0, in_ready=1 from the next cycle, all out_* = 0, illegal_cnt=0. Buffered entries are discarded.
- Reset mid-operation aborts all in-flight entries. An accept in the same cycle as rst is ignored.
- FIFO pointers wrap modulo 2.

Test Plan:
- XLEN=32, out_ready=1, push 0xFFF00093 (ADDI x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Back-to-back push 0xFE20AE23 (SW, -4), 0x00000463 (BEQ, +8), 0x123450B7 (LUI), 0x4030D093 (SRAI 3) -> consecutive cycles give imm 0xFFFFFFFC/S, 0x00000008/B, 0x12345000/U, 0x00000003/SHAMT (not 0x403).
- out_ready=0, in_valid=1 held with tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 from the cycle after the second accept. Head holds tag 1 stable. Raising out_ready drains 1,2,3 in order with no loss or duplication.
- Push 0x0000007F three times with CNT_W=2 -> out_illegal=1, out_imm=0, out_fmt=0; illegal_cnt goes 1,2,3 and stays 3 on a fourth push.
- XLEN=64, push 0xFFF00093 and 0x800000B7 -> out_imm=0xFFFFFFFFFFFFFFFF and 0xFFFFFFFF80000000. Push 0x03F0D093 (SRLI 63) -> imm 0x3F.
- Fill FIFO to 2, assert rst for one cycle with in_valid=1 -> next cycle out_valid=0, illegal_cnt=0, in_ready=1, nothing from the reset cycle appears.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry result queue.
// Latency 1 cycle accept-to-head; in_ready is registered (count < 2), no path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     imm32;
    logic [5:0]      shamt;
    logic            is_shamt;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    // RV64 shifts take a 6-bit shamt; RV32 only 5 bits (bit 25 belongs to funct7).
    assign shamt  = {(XLEN == 64) & in_instr[25], in_instr[24:20]};

    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        is_shamt    = 1'b0;
        imm32       = '0;
        unique case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt  = FMT_SHAMT;
                    is_shamt = 1'b1;
                end else begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: dec_fmt = FMT_NONE;
            default:    dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = is_shamt ? XLEN'(shamt) : XLEN'($signed(imm32));

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       accept;
    logic       pop;
    entry_t     head;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (accept && !pop)
                count <= count + 2'd1;
            else if (pop && !accept)
                count <= count - 2'd1;
            if (accept && dec_illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    // Entries are not reset, so the head is masked whenever the queue is empty.
    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_fmt     = out_valid ? head.fmt     : 3'd0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign out_tag     = out_valid ? head.tag     : '0;

endmodule
